// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent snapshot,
// per-slot anti-ghosting blank, optional hex glyphs and leading-zero blanking.
module seven_segment_scan #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SCAN_DIV      = 100000,
  parameter int unsigned BLANK_CYC     = 1000,
  parameter int unsigned HEX_EN        = 1,
  parameter int unsigned AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PreW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [PreW-1:0]   PreLast  = PreW'(SCAN_DIV - 1);
  localparam logic [PreW-1:0]   PreBlank = PreW'(BLANK_CYC);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AnOff    = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PreW-1:0]     pre_q, pre_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q;
  logic [DIGITS-1:0]   dp_snap_q;
  logic                load;
  logic [3:0]          nib;
  logic                dp_cur;
  logic                upper_nz;
  logic                lz_blank;
  logic                lit;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (HEX_EN == 0 && n > 4'h9) g = 7'b1111111;
    return g;
  endfunction

  always_comb begin
    pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PreLast) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    // Snapshot only at the start of a frame so mid-scan updates never tear.
    load = (pre_q == '0) && (idx_q == '0);
  end

  always_comb begin
    nib      = '0;
    dp_cur   = 1'b0;
    upper_nz = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IdxW'(i) == idx_q) begin
        nib    = snap_q[4*i +: 4];
        dp_cur = dp_snap_q[i];
      end
      if (IdxW'(i) >= idx_q && snap_q[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    lz_blank = blank_lz && (idx_q != '0) && !upper_nz;
    lit      = enable && (pre_q >= PreBlank);
    seg_d    = 8'hFF;
    an_d     = AnOff;
    if (lit) begin
      // Blanked digits keep their anode so brightness stays uniform.
      seg_d = {~dp_cur, lz_blank ? 7'b1111111 : decode(nib)};
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (IdxW'(i) == idx_q) an_d[i] = ~AnOff[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      dp_snap_q <= '0;
      seg       <= 8'hFF;
      an        <= AnOff;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      if (load) begin
        snap_q    <= value;
        dp_snap_q <= dp_in;
      end
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench: stimulus pushes per-cycle expected {an, seg}; a negedge monitor
// pops and compares against the HEX_EN=1 DUT and a HEX_EN=0 twin.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [7:0]  seg, seg_nh;
  logic [3:0]  an, an_nh;

  always #5 clk = ~clk;

  seven_segment_scan #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_EN(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .value(value), .dp_in(dp_in), .seg(seg), .an(an)
  );

  seven_segment_scan #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_EN(0), .AN_ACTIVE_LOW(1)
  ) dut_nh (
    .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .value(value), .dp_in(dp_in), .seg(seg_nh), .an(an_nh)
  );

  typedef struct {
    int         stamp;
    logic [3:0] an;
    logic [7:0] seg;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t qh[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.stamp != cyc) begin
        errors++;
        $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d", e.name, e.stamp, cyc);
      end else if (an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL %s @%0d: got an=%b seg=%h, required an=%b seg=%h",
                 e.name, cyc, an, seg, e.an, e.seg);
      end
    end
    while (qh.size() > 0 && qh[0].stamp <= cyc) begin
      e = qh.pop_front();
      checks++;
      if (e.stamp != cyc) begin
        errors++;
        $display("FAIL %s: entry for cycle %0d not checked, now cycle %0d", e.name, e.stamp, cyc);
      end else if (an_nh !== e.an || seg_nh !== e.seg) begin
        errors++;
        $display("FAIL %s @%0d: got an=%b seg=%h, required an=%b seg=%h",
                 e.name, cyc, an_nh, seg_nh, e.an, e.seg);
      end
    end
  end

  // segs = {digit3, digit2, digit1, digit0}; offsets first..last from frame start base.
  task automatic push_frame(input int base, input logic [31:0] segs, input int first,
                            input int last, input int dlo, input int dhi,
                            input string name, input bit nh);
    for (int k = first; k <= last; k++) begin
      int   d  = (k / 4) % 4;
      int   p  = k % 4;
      int   st = base + k;
      exp_t e;
      e.stamp = st;
      e.name  = name;
      if (p == 0 || (st >= dlo && st <= dhi)) begin
        e.an  = 4'hF;
        e.seg = 8'hFF;
      end else begin
        e.an  = ~(4'b0001 << d);
        e.seg = segs[8*d +: 8];
      end
      if (nh) qh.push_back(e);
      else q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle of the first post-release (snapshot) edge.
  task automatic do_reset(output int base);
    exp_t e;
    e.stamp = cyc + 1;
    e.an    = 4'hF;
    e.seg   = 8'hFF;
    e.name  = "reset_dark";
    q.push_back(e);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = cyc + 1;
  endtask

  initial begin
    int b;
    @(negedge clk);
    @(negedge clk);
    value  = 16'h1234;
    enable = 1'b1;
    do_reset(b);
    push_frame(b, 32'hF9A4B099, 0, 31, -1, -1, "dec_1234", 1'b0);

    wait_cyc(b + 31);
    value = 16'hABCD;
    b += 32;
    push_frame(b, 32'h8883C6A1, 0, 15, -1, -1, "hex_abcd", 1'b0);
    push_frame(b, 32'hFFFFFFFF, 0, 15, -1, -1, "hex_off", 1'b1);

    wait_cyc(b + 15);
    blank_lz = 1'b1;
    value    = 16'h0050;
    b += 16;
    push_frame(b, 32'hFFFF92C0, 0, 15, -1, -1, "lz_0050", 1'b0);

    wait_cyc(b + 15);
    value = 16'h0000;
    b += 16;
    push_frame(b, 32'hFFFFFFC0, 0, 15, -1, -1, "lz_zero", 1'b0);

    wait_cyc(b + 15);
    dp_in = 4'b0100;
    b += 16;
    push_frame(b, 32'hFF7FFFC0, 0, 15, -1, -1, "dp_blanked", 1'b0);

    wait_cyc(b + 15);
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    value    = 16'h1111;
    b += 16;
    push_frame(b, 32'hF9F9F9F9, 0, 15, -1, -1, "snap_old", 1'b0);
    push_frame(b + 16, 32'hA4A4A4A4, 0, 15, -1, -1, "snap_new", 1'b0);
    wait_cyc(b + 9);
    value = 16'h2222;
    wait_cyc(b + 31);
    b += 32;

    push_frame(b, 32'hA4A4A4A4, 0, 9, -1, -1, "pre_reset", 1'b0);
    wait_cyc(b + 9);
    do_reset(b);
    push_frame(b, 32'hA4A4A4A4, 0, 15, -1, -1, "post_reset", 1'b0);

    push_frame(b + 16, 32'hA4A4A4A4, 0, 31, b + 22, b + 25, "enable", 1'b0);
    wait_cyc(b + 21);
    enable = 1'b0;
    wait_cyc(b + 25);
    enable = 1'b1;
    wait_cyc(b + 48);

    for (int i = 0; i < 10 && (q.size() > 0 || qh.size() > 0); i++) @(negedge clk);
    checks++;
    if (q.size() > 0 || qh.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size() + qh.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
